// File: rtl/hart_mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hart_mem_arbiter_if
// Brief    : Hart-side request bundle and memory-port grant/busy fan-out.
// Revision : 1.0  initial release
// ============================================================================
interface hart_mem_arbiter_if #(
    parameter int N_HARTS = 2,
    parameter int BUS_W   = 160,
    parameter int QW      = 8,
    parameter int SEL_W   = $clog2(N_HARTS + 1)
);
    logic                       i_freeze;
    logic [N_HARTS-1:0]         i_req;
    logic [N_HARTS-1:0]         i_safe;
    logic [QW-1:0]              i_quantum;
    logic [N_HARTS*BUS_W-1:0]   i_hart_bus;
    logic                       i_busy;
    logic                       i_dram_busy;
    logic [SEL_W-1:0]           o_sel;
    logic [N_HARTS-1:0]         o_sel_oh;
    logic [BUS_W-1:0]           o_bus;
    logic                       o_valid;
    logic [N_HARTS-1:0]         o_core_busy;
    logic [N_HARTS-1:0]         o_core_dram_busy;
    logic                       o_switch;

    modport slave (
        input  i_freeze, i_req, i_safe, i_quantum, i_hart_bus, i_busy, i_dram_busy,
        output o_sel, o_sel_oh, o_bus, o_valid, o_core_busy, o_core_dram_busy, o_switch
    );

    modport master (
        output i_freeze, i_req, i_safe, i_quantum, i_hart_bus, i_busy, i_dram_busy,
        input  o_sel, o_sel_oh, o_bus, o_valid, o_core_busy, o_core_dram_busy, o_switch
    );
endinterface
`default_nettype wire

// File: rtl/hart_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hart_mem_arbiter
// Brief    : Time-multiplexes one memory port among harts, switching only at
//            hart safe points, with quantum, masking and a one-cycle bubble.
// Revision : 1.0  initial release
// ============================================================================
module hart_mem_arbiter #(
    parameter int N_HARTS = 2,
    parameter int BUS_W   = 160,
    parameter int QW      = 8,
    parameter int SEL_W   = $clog2(N_HARTS + 1)
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    hart_mem_arbiter_if.slave    bus
);
    localparam logic [0:0]    c_ST_RUN    = 1'b0;
    localparam logic [0:0]    c_ST_BUBBLE = 1'b1;
    localparam logic [QW-1:0] c_CNT_MAX   = '1;

    logic [0:0]         r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [QW-1:0]      r_cnt;
    logic               r_switch;

    logic [N_HARTS-1:0] w_sel_oh;
    logic [N_HARTS-1:0] w_other_req;
    logic               w_safe_cur;
    logic               w_req_cur;
    logic               w_run;
    logic               w_sw;
    logic               w_found;
    logic [SEL_W-1:0]   w_nxt;
    logic [BUS_W-1:0]   w_bus;

    generate
        for (genvar g = 0; g < N_HARTS; g++) begin : g_sel_oh
            assign w_sel_oh[g] = (r_sel == SEL_W'(g));
        end
    endgenerate

    assign w_other_req = bus.i_req & ~w_sel_oh;
    assign w_safe_cur  = |(bus.i_safe & w_sel_oh);
    assign w_req_cur   = |(bus.i_req & w_sel_oh);
    assign w_run       = (r_state == c_ST_RUN);

    // A parked (non-requesting) owner gives up the port regardless of quantum.
    assign w_sw = !bus.i_freeze && w_safe_cur
                  && ((r_cnt >= bus.i_quantum) || !w_req_cur)
                  && (|w_other_req);

    // Round-robin: nearest requester after the owner, wrapping past the top.
    always_comb begin
        w_nxt   = r_sel;
        w_found = 1'b0;
        for (int k = 1; k < N_HARTS; k++) begin
            for (int g = 0; g < N_HARTS; g++) begin
                if (!w_found && bus.i_req[g]
                    && ((int'(r_sel) + k == g) || (int'(r_sel) + k == g + N_HARTS))) begin
                    w_nxt   = SEL_W'(g);
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_bus = '0;
        for (int g = 0; g < N_HARTS; g++) begin
            if (w_sel_oh[g]) begin
                w_bus = bus.i_hart_bus[g*BUS_W +: BUS_W];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state  <= c_ST_RUN;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_switch <= 1'b0;
        end else begin
            r_switch <= 1'b0;
            case (r_state)
                c_ST_RUN: begin
                    if (w_sw) begin
                        r_sel    <= w_nxt;
                        r_cnt    <= '0;
                        r_state  <= c_ST_BUBBLE;
                        r_switch <= 1'b1;
                    end else if (!bus.i_freeze && (r_cnt != c_CNT_MAX)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_RUN;
                end
            endcase
        end
    end

    assign bus.o_sel            = r_sel;
    assign bus.o_sel_oh         = w_sel_oh;
    assign bus.o_bus            = w_bus;
    assign bus.o_valid          = w_run;
    assign bus.o_switch         = r_switch;
    // Only the running owner sees the real busy; everyone else is stalled.
    assign bus.o_core_busy      = w_run ? (~w_sel_oh | {N_HARTS{bus.i_busy}})      : '1;
    assign bus.o_core_dram_busy = w_run ? (~w_sel_oh | {N_HARTS{bus.i_dram_busy}}) : '1;
endmodule
`default_nettype wire

// File: doc/hart_mem_arbiter.md
Name: hart_mem_arbiter

Overview:
- Parametrised shared-memory-port arbiter for an N-hart cluster.
- Time-multiplexes one memory/MMU port among harts. Switches only at hart-reported safe points.
- Adds request masking, a programmable time quantum and a one-cycle switch bubble.
- Sits between the per-hart core+MMU instances and the single memory controller port; muxes each hart's flattened request bus and fans busy back out.

Parameters:
- N_HARTS, 2, number of harts; legal range 1..16.
- BUS_W, 160, width of one hart's flattened request bus (addresses, wdata, ctrl, TLB/PTE fields).
- QW, 8, width of the quantum register/counter.
- SEL_W, $clog2(N_HARTS+1), width of the hart index.

Ports:
- CLK  in  1  clock.
- RST_X  in  1  asynchronous active-low reset.
- i_freeze  in  1  1 = no switching allowed (memory-controller mode active, or CPU mode not current).
- i_req  in  N_HARTS  hart g wants the port (not halted/parked).
- i_safe  in  N_HARTS  hart g is at a switchable boundary (next state idle, no CSR op in EX/MEM, insn taken).
- i_quantum  in  QW  minimum cycles a hart keeps the port; 0 = switch at every safe point.
- i_hart_bus  in  N_HARTS*BUS_W  hart g's request bus at bits [g*BUS_W +: BUS_W].
- i_busy  in  1  memory port busy.
- i_dram_busy  in  1  DRAM/page-walk busy.
- o_sel  out  SEL_W  granted hart index.
- o_sel_oh  out  N_HARTS  one-hot of o_sel.
- o_bus  out  BUS_W  i_hart_bus slice of o_sel.
- o_valid  out  1  0 during the switch bubble.
- o_core_busy  out  N_HARTS  per-hart busy.
- o_core_dram_busy  out  N_HARTS  per-hart DRAM busy.
- o_switch  out  1  one-cycle pulse on grant change.

Behaviour:
- Reset (async, RST_X=0): state=RUN, sel=0, cnt=0, o_switch=0, o_valid=1, o_sel_oh=1.
- Reset exit is synchronous to CLK.
- FSM has two states: RUN and BUBBLE.
- RUN, switch condition evaluated each cycle: sw = !i_freeze & i_safe[sel] & ((cnt >= i_quantum) | !i_req[sel]) & (other_req != 0).
  - other_req = i_req with bit sel cleared.
- RUN, on sw:
  - nxt = first g with i_req[g], searching sel+1, sel+2, … cyclically (index wraps N_HARTS-1 -> 0).
  - At the clock edge: sel <= nxt, cnt <= 0, state <= BUBBLE, o_switch <= 1.
- RUN, otherwise: cnt <= cnt+1, saturating at 2^QW-1.
  - cnt holds while i_freeze=1.
- BUBBLE lasts exactly one cycle, then state <= RUN; o_switch <= 0.
  - i_freeze is ignored in BUBBLE: the bubble always completes.
- o_valid = (state==RUN).
- o_sel, o_sel_oh and o_bus always reflect the registered sel; o_bus is combinational from sel (no added latency).
- o_core_busy[g] = (state==RUN && sel==g) ? i_busy : 1.
- o_core_dram_busy[g] has the same rule, using i_dram_busy.
  - Every hart sees busy=1 during BUBBLE.
- If no hart requests, or only sel requests, sel stays put; a non-requesting sel still holds the port.
- Hart masked (i_req low) while selected: it loses the port at its next safe point, if any other hart requests.
- N_HARTS=1: sw is never true; block degenerates to a pass-through with o_valid=1.
- Mid-operation reset: returns immediately to the reset state; no partial switch survives.
- i_quantum change takes effect on the next comparison. Lowering it below cnt forces eligibility at the next safe point.
- With i_quantum=0 and all i_req=1, grants rotate at every safe point of the current hart.

Test Plan:
- N_HARTS=4, i_req=4'b1111, i_quantum=0, pulse i_safe[sel] each 5 cycles -> o_sel sequence 0,1,2,3,0.
  - One o_switch pulse and one o_valid=0 cycle per change; o_core_busy=4'b1111 in each bubble.
- i_quantum=10, i_safe[0] held 1 -> switch edge on cycle 11 after reset (cnt reaches 10), o_sel=1; o_switch asserted 1 cycle.
- i_req=4'b1001, sel=0, safe -> o_sel jumps 0->3, skipping masked 1,2; next switch 3->0 (wrap).
- i_freeze=1 with i_safe and quantum expired for 50 cycles -> o_sel unchanged, cnt frozen; drop i_freeze -> switch on next edge.
- Selected hart 2 drops i_req, i_quantum=255, i_safe[2]=1 -> immediate switch to next requester despite quantum; only i_req[2] set -> no switch.
- Assert RST_X=0 during BUBBLE -> outputs return to reset values asynchronously (o_sel=0, o_valid=1, o_switch=0) before the next edge.
